// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared types and helpers for the Ethernet TX arbiter
// Contents: arbiter state enum, id-width helper, default IFG and frame-limit constants.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int DEF_IFG_CYCLES       = 24;
    localparam int DEF_MAX_FRAME_CYCLES = 4096;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// rtl/eth_tx_arbiter_if.sv - requester/MAC bundle of the Ethernet TX arbiter
// Signals: req/req_data/req_en/req_busy per requester, gnt/abort per requester,
// mac_data/mac_en/mac_busy toward the MAC, active and cur_id status.
// Modports: slave (arbiter side), master (requesters + MAC side).
interface eth_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    import eth_tx_arb_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_en;
    logic [N_REQ-1:0]   req_busy;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   abort;
    logic [7:0]         mac_data;
    logic               mac_en;
    logic               mac_busy;
    logic               active;
    logic [ID_W-1:0]    cur_id;

    modport slave (
        input  req, req_data, req_en, mac_busy,
        output req_busy, gnt, abort, mac_data, mac_en, active, cur_id
    );

    modport master (
        output req, req_data, req_en, mac_busy,
        input  req_busy, gnt, abort, mac_data, mac_en, active, cur_id
    );

endinterface

// File: rtl/eth_tx_arbiter_rr_pick.sv
// rtl/eth_tx_arbiter_rr_pick.sv - combinational round-robin picker
// Ports: req_i (request vector), last_i (last winner) -> valid_o (any request),
// idx_o (first set request searching upward from last_i+1 with wrap).
module rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  idx_o
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx_o = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin arbiter sharing one MAC byte-send port
// Ports: clk, rst (async active-low), bus (eth_tx_arbiter_if.slave):
//   req/req_data/req_en in, req_busy/gnt/abort out per requester;
//   mac_data/mac_en out, mac_busy in; active, cur_id status out.
// Optional: ETH_TX_ARB_WATCHDOG_EN adds a grant-duration watchdog with abort
// pulse and per-requester re-grant mask; without it abort is held at 0.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int N_REQ            = 2,
    parameter int IFG_CYCLES       = DEF_IFG_CYCLES,
    parameter int MAX_FRAME_CYCLES = DEF_MAX_FRAME_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    eth_tx_arbiter_if.slave   bus
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int GAP_W = id_width(IFG_CYCLES);

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [ID_W-1:0]  cur_id_q;
    logic [ID_W-1:0]  last_q;
    logic [GAP_W-1:0] gap_q;

    logic [N_REQ-1:0] req_eff;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [7:0]       req_bytes [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_bytes[i] = bus.req_data[8*i +: 8];
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int                WD_W     = $clog2(MAX_FRAME_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(MAX_FRAME_CYCLES - 1);

    logic [WD_W-1:0]  wdog_q;
    logic [N_REQ-1:0] abort_q;
    logic [N_REQ-1:0] mask_q;
    logic             wdog_fire;

    // Fires on the edge that would start grant cycle MAX_FRAME_CYCLES.
    assign wdog_fire = (state_q == GRANT) && bus.req[cur_id_q] && (wdog_q == WD_LIMIT);

    // An aborted requester stays masked until its req is sampled low once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= (mask_q & bus.req) | (wdog_fire ? gnt_q : '0);
        end
    end

    assign req_eff   = bus.req & ~mask_q;
    assign bus.abort = abort_q;
`else
    assign req_eff   = bus.req;
    assign bus.abort = '0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (req_eff),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_onehot = N_REQ'(1) << pick_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            cur_id_q <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            gap_q    <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            wdog_q   <= '0;
            abort_q  <= '0;
`endif
        end else begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
            abort_q <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q    <= pick_onehot;
                        cur_id_q <= pick_idx;
                        last_q   <= pick_idx;
                        state_q  <= GRANT;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                        wdog_q   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req[cur_id_q]) begin
                        gnt_q   <= '0;
                        state_q <= DRAIN;
                    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    else if (wdog_fire) begin
                        gnt_q   <= '0;
                        abort_q <= gnt_q;
                        state_q <= DRAIN;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    // Wait for the MAC to finish the last byte before the gap starts.
                    if (!bus.mac_busy) begin
                        if (IFG_CYCLES > 0) begin
                            gap_q   <= GAP_W'(IFG_CYCLES - 1);
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.cur_id   = cur_id_q;
    assign bus.active   = (state_q != IDLE);
    assign bus.mac_data = (gnt_q != '0) ? req_bytes[cur_id_q] : 8'h00;
    assign bus.mac_en   = bus.req_en[cur_id_q] & gnt_q[cur_id_q];
    assign bus.req_busy = ~gnt_q | {N_REQ{bus.mac_busy}};

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    eth_tx_arbiter_if #(.N_REQ(2)) bus ();

    eth_tx_arbiter #(
        .N_REQ            (2),
        .IFG_CYCLES       (24),
        .MAX_FRAME_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (bus.gnt == 2'b00 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.active && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.active}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int gnt_cnt;
        int abort_cnt;
        int abort_t;
        logic [1:0] exp4 [4];

        n_checks = 0;
        n_errors = 0;
        exp4 = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst          = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_en   = '0;
        bus.mac_busy = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_abort", bus.abort, 2'b00);
        check("rst_active", bus.active, 1'b0);
        check("rst_cur_id", bus.cur_id, 1'b0);
        check("rst_mac_en", bus.mac_en, 1'b0);
        check("rst_mac_data", bus.mac_data, 8'h00);
        check("rst_req_busy", bus.req_busy, 2'b11);
        rst = 1'b1;
        tick();

        // 1: contention, requester 0 first; next grant 26 clk after req[0] low
        bus.req = 2'b11;
        tick();
        check("t1_gnt", bus.gnt, 2'b01);
        check("t1_cur_id", bus.cur_id, 1'b0);
        check("t1_active", bus.active, 1'b1);
        bus.req = 2'b10;
        tick();
        check("t1_drop_gnt", bus.gnt, 2'b00);
        wait_gnt(n);
        check("t1_ifg_latency", n, 26);
        check("t1_gnt2", bus.gnt, 2'b10);
        check("t1_cur_id2", bus.cur_id, 1'b1);
        bus.req = 2'b00;
        wait_idle("t1_idle");

        // 2: requester 1 streams 60 bytes; requester 0 drives garbage strobes
        bus.req = 2'b10;
        tick();
        check("t2_gnt", bus.gnt, 2'b10);
        for (int b = 0; b < 60; b++) begin
            bus.req_data = {b[7:0], 8'hA5};
            bus.req_en   = 2'b11;
            bus.mac_busy = b[0];
            #1;
            check("t2_mac_data", bus.mac_data, b[7:0]);
            check("t2_mac_en", bus.mac_en, 1'b1);
            check("t2_req_busy", bus.req_busy, {b[0], 1'b1});
            tick();
        end
        bus.req_en   = 2'b01;
        bus.mac_busy = 1'b0;
        #1;
        check("t2_garbage_en", bus.mac_en, 1'b0);
        bus.req_en = 2'b00;
        bus.req    = 2'b00;
        wait_idle("t2_idle");

        // 3: drop while MAC busy for 10 clk; no grant until gap expires
        bus.req = 2'b01;
        tick();
        check("t3_gnt", bus.gnt, 2'b01);
        bus.mac_busy = 1'b1;
        bus.req      = 2'b00;
        tick();
        bus.req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_drain_active", bus.active, 1'b1);
            check("t3_drain_gnt", bus.gnt, 2'b00);
        end
        bus.mac_busy = 1'b0;
        tick();
        wait_gnt(n);
        check("t3_gap_latency", n, 25);
        check("t3_gnt_after", bus.gnt, 2'b10);
        bus.req = 2'b00;
        wait_idle("t3_idle");

        // 4: both requesting for four frames -> 0,1,0,1
        bus.req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_gnt(n);
            check("t4_order", bus.gnt, exp4[f]);
            tick();
            tick();
            tick();
            if (f < 3) begin
                bus.req = ~exp4[f];
                tick();
                bus.req = 2'b11;
            end
        end

        // 5: reset mid-frame while requester 1 is sending
        bus.req_en   = 2'b10;
        bus.req_data = 16'h5A00;
        #1;
        check("t5_pre_mac_en", bus.mac_en, 1'b1);
        check("t5_pre_mac_data", bus.mac_data, 8'h5A);
        rst = 1'b0;
        #1;
        check("t5_rst_gnt", bus.gnt, 2'b00);
        check("t5_rst_mac_en", bus.mac_en, 1'b0);
        check("t5_rst_active", bus.active, 1'b0);
        check("t5_rst_abort", bus.abort, 2'b00);
        tick();
        tick();
        rst        = 1'b1;
        bus.req    = 2'b10;
        bus.req_en = 2'b00;
        tick();
        check("t5_regrant", bus.gnt, 2'b10);
        check("t5_cur_id", bus.cur_id, 1'b1);
        bus.req = 2'b00;
        wait_idle("t5_idle");

        // 6: requester 0 holds req for 200 clk
        bus.req = 2'b01;
        tick();
        check("t6_gnt", bus.gnt, 2'b01);
        gnt_cnt   = 1;
        abort_cnt = 0;
        abort_t   = -1;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (bus.gnt[0]) gnt_cnt++;
            if (bus.abort[0]) begin
                abort_cnt++;
                abort_t = t;
            end
        end
        bus.req = 2'b00;
        tick();
        bus.req = 2'b01;
        wait_gnt(n);
`ifdef ETH_TX_ARB_WATCHDOG_EN
        check("t6_gnt_cycles", gnt_cnt, 100);
        check("t6_abort_count", abort_cnt, 1);
        check("t6_abort_cycle", abort_t, 100);
        check("t6_regrant_latency", n, 1);
`else
        check("t6_gnt_cycles", gnt_cnt, 201);
        check("t6_abort_count", abort_cnt, 0);
        check("t6_regrant_latency", n, 26);
`endif
        check("t6_regrant", bus.gnt, 2'b01);
        bus.req = 2'b00;
        wait_idle("t6_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Round-robin arbiter sharing one MAC byte-send interface (SEND_DATA/SEND_EN/SENT_BUSY style) between N frame sources, e.g. the ARP generator and a UDP sender.
- Grants one requester per frame and muxes its byte stream to the MAC.
- Enforces a drain plus inter-frame gap before the next grant.
- Sits between the packet builders and RTL8201_MII_MAC.

Parameters:
N_REQ, 2, number of requesters (2..8)
IFG_CYCLES, 24, clk cycles of idle gap after MAC drains; 0 means no gap
MAX_FRAME_CYCLES, 4096, watchdog limit on grant duration (used only with the optional feature)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester frame request; held high for the whole frame
req_data  in  8*N_REQ  byte from requester i at bits [8i+7:8i]
req_en  in  N_REQ  byte-valid strobe from requester i
req_busy  out  N_REQ  back-pressure to requester i
gnt  out  N_REQ  one-hot grant, registered
abort  out  N_REQ  one-cycle pulse to a requester whose grant was revoked
mac_data  out  8  byte to MAC (SEND_DATA)
mac_en  out  1  byte strobe to MAC (SEND_EN)
mac_busy  in  1  MAC busy (SENT_BUSY)
active  out  1  high in every state except IDLE
cur_id  out  clog2(N_REQ)  index of current or last granted requester

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; gnt=0, abort=0, active=0, cur_id=0.
  - last pointer=N_REQ-1, so requester 0 wins the first contention.
  - gap counter=0, watchdog counter=0.
- Muxing (combinational from registered gnt/cur_id):
  - mac_data = gnt!=0 ? req_data[cur_id] : 8'h00.
  - mac_en = req_en[cur_id] & gnt[cur_id].
  - req_busy[i] = gnt[i] ? mac_busy : 1.
  - req_en from non-granted requesters is ignored.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from last+1 with wrap.
  - On the next edge: gnt[pick]=1, cur_id=pick, last=pick, state->GRANT.
  - Latency from req rising to gnt = 1 clk.
- GRANT:
  - Hold gnt while req[cur_id]=1.
  - When req[cur_id]=0 is sampled: gnt cleared on that edge, state->DRAIN.
  - Requests from others are not serviced until the cycle leaves IDLE again (no preemption).
- DRAIN:
  - Wait until mac_busy=0 is sampled.
  - Then, if IFG_CYCLES>0: load gap counter with IFG_CYCLES-1, state->GAP.
  - Otherwise state->IDLE.
- GAP: decrement each clk; at 0 -> IDLE. The next grant is therefore issued IFG_CYCLES+1 clk after drain completes.
- Simultaneous events:
  - req drop and mac_busy=0 in the same cycle: still go through DRAIN. DRAIN lasts 1 clk.
  - The same requester re-raising req during DRAIN/GAP waits for IDLE and competes normally by round-robin.
- Round-robin fairness: with all requests continuously asserted, grants cycle 0,1,...,N_REQ-1,0.
- Reset mid-frame: gnt drops immediately, mac_en goes 0 combinationally, no abort pulse.

Optional Feature:
Macro ETH_TX_ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - On reaching MAX_FRAME_CYCLES: gnt cleared, abort[cur_id] pulses for 1 clk, state->DRAIN.
  - The requester must drop req before it can be granted again; its req is masked until it is seen low for 1 clk.
- Not defined: no counter or mask logic; abort is tied to 0.

Decomposition:
- Package eth_tx_arb_pkg:
  - state enum IDLE/GRANT/DRAIN/GAP (2-bit).
  - clog2 id-width function.
  - default IFG and MAX_FRAME constants.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: valid, index.
  - Reusable by a future RX dispatcher.

Test Plan:
1. After reset, req=2'b11 -> gnt=2'b01 one clk later, cur_id=0. Frame ends with req[0]=0, mac_busy=0, IFG_CYCLES=24 -> gnt=2'b10 exactly 26 clk after req[0] is sampled low.
2. req[1] only, requester 1 sends 60 bytes (0x00..0x3B) with req_en -> mac_data/mac_en match byte-for-byte. req_busy[0]=1 throughout. Garbage req_en[0] is never seen on mac_en.
3. Requester 0 drops req while mac_busy=1 for 10 clk -> state stays DRAIN 10 clk, active=1, no grant until gap expires.
4. Both reqs held for 4 frames -> grant order 0,1,0,1.
5. rst asserted in GRANT mid-frame -> gnt=0, mac_en=0, active=0 immediately. After release, req=2'b10 -> gnt=2'b10.
6. With ETH_TX_ARB_WATCHDOG_EN and MAX_FRAME_CYCLES=100, requester 0 holds req 200 clk:
   - abort[0] pulses at grant cycle 100 and gnt[0] drops.
   - req[0] is not re-granted until it goes low.
   - Without the macro, gnt[0] holds all 200 clk.
